// File: rtl/gas_link_pkg.sv
// rtl/gas_link_pkg.sv - gas code and signature table shared by both ends of the gas-detector link
package gas_link_pkg;

  localparam int SIG_LEN = 8;

  typedef enum logic [2:0] {
    GAS_NONE    = 3'd0,
    GAS_METHANE = 3'd1,
    GAS_CO      = 3'd2,
    GAS_LPG     = 3'd3,
    GAS_H2S     = 3'd4
  } gas_code_e;

  localparam logic [SIG_LEN-1:0] SIG_METHANE = 8'b1010_1001;
  localparam logic [SIG_LEN-1:0] SIG_CO      = 8'b1100_0101;
  localparam logic [SIG_LEN-1:0] SIG_LPG     = 8'b1110_0011;
  localparam logic [SIG_LEN-1:0] SIG_H2S     = 8'b1001_1011;

  typedef struct packed {
    logic               supported;
    logic [SIG_LEN-1:0] signature;
  } sig_entry_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SEND = 2'd1,
    ST_GAP  = 2'd2
  } ser_state_e;

  function automatic sig_entry_t sig_lookup(input logic [2:0] code);
    sig_entry_t e;
    case (code)
      GAS_METHANE: e = '{supported: 1'b1, signature: SIG_METHANE};
      GAS_CO:      e = '{supported: 1'b1, signature: SIG_CO};
      GAS_LPG:     e = '{supported: 1'b1, signature: SIG_LPG};
      GAS_H2S:     e = '{supported: 1'b1, signature: SIG_H2S};
      default:     e = '{supported: 1'b0, signature: '0};
    endcase
    return e;
  endfunction

endpackage

// File: rtl/gas_signature_serializer.sv
// rtl/gas_signature_serializer.sv - serialises a gas code's signature MSB first, followed by a zero gap
module gas_signature_serializer
  import gas_link_pkg::*;
#(
  parameter int SIG_W      = 8,
  parameter int GAP_CYCLES = 4
) (
  input  logic       clk,
  input  logic       arst,
  input  logic [2:0] code_in,
  input  logic       code_valid,
  output logic       code_ready,
  output logic       dout,
  output logic       busy,
  output logic       done,
  output logic       err
);

  localparam int CNT_W = $clog2(SIG_W);

  ser_state_e             state_q, state_d;
  logic [SIG_W-1:0]       shreg_q, shreg_d;
  logic [CNT_W-1:0]       bit_cnt_q, bit_cnt_d;
  logic [3:0]             gap_cnt_q, gap_cnt_d;
  logic                   armed_q;
  logic                   dout_q, dout_d;
  logic                   busy_q, busy_d;
  logic                   done_q, done_d;
  logic                   err_q, err_d;
  logic                   ready_q, ready_d;
  sig_entry_t             entry;
  logic                   accept;

  assign entry  = sig_lookup(code_in);
  // armed_q blocks an accept on the first edge after reset release
  assign accept = armed_q && code_valid && (state_q == ST_IDLE);

  always_comb begin
    state_d   = state_q;
    shreg_d   = shreg_q;
    bit_cnt_d = bit_cnt_q;
    gap_cnt_d = gap_cnt_q;
    dout_d    = 1'b0;
    busy_d    = 1'b0;
    done_d    = 1'b0;
    err_d     = 1'b0;
    ready_d   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        ready_d = 1'b1;
        if (accept) begin
          if (entry.supported) begin
            shreg_d   = SIG_W'(entry.signature);
            bit_cnt_d = CNT_W'(SIG_W - 1);
            state_d   = ST_SEND;
            ready_d   = 1'b0;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      ST_SEND: begin
        dout_d  = shreg_q[SIG_W-1];
        busy_d  = 1'b1;
        shreg_d = {shreg_q[SIG_W-2:0], 1'b0};
        if (bit_cnt_q == '0) begin
          gap_cnt_d = 4'(GAP_CYCLES - 1);
          state_d   = ST_GAP;
        end else begin
          bit_cnt_d = bit_cnt_q - 1'b1;
        end
      end
      ST_GAP: begin
        busy_d = 1'b1;
        if (gap_cnt_q == 4'd0) begin
          done_d  = 1'b1;
          ready_d = 1'b1;
          state_d = ST_IDLE;
        end else begin
          gap_cnt_d = gap_cnt_q - 4'd1;
        end
      end
      default: begin
        ready_d = 1'b1;
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge arst) begin
    if (!arst) begin
      state_q   <= ST_IDLE;
      shreg_q   <= '0;
      bit_cnt_q <= '0;
      gap_cnt_q <= '0;
      armed_q   <= 1'b0;
      dout_q    <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
      ready_q   <= 1'b1;
    end else begin
      state_q   <= state_d;
      shreg_q   <= shreg_d;
      bit_cnt_q <= bit_cnt_d;
      gap_cnt_q <= gap_cnt_d;
      armed_q   <= 1'b1;
      dout_q    <= dout_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      err_q     <= err_d;
      ready_q   <= ready_d;
    end
  end

  assign code_ready = ready_q;
  assign dout       = dout_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign err        = err_q;

endmodule

// File: tb/tb_gas_signature_serializer.sv
// tb/tb_gas_signature_serializer.sv - randomized self-checking bench with a frame-schedule reference model
module tb_gas_signature_serializer;

  localparam int SIG_W      = 8;
  localparam int GAP_CYCLES = 4;

  logic       clk = 1'b0;
  logic       arst = 1'b1;
  logic [2:0] code_in = 3'd0;
  logic       code_valid = 1'b0;
  logic       code_ready, dout, busy, done, err;

  gas_signature_serializer #(.SIG_W(SIG_W), .GAP_CYCLES(GAP_CYCLES)) dut (
    .clk        (clk),
    .arst       (arst),
    .code_in    (code_in),
    .code_valid (code_valid),
    .code_ready (code_ready),
    .dout       (dout),
    .busy       (busy),
    .done       (done),
    .err        (err)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0h expected %0h", nm, $time, act, exp);
    end
  endtask

  function automatic bit ref_sig(input logic [2:0] c, output logic [7:0] s);
    case (c)
      3'd1: begin s = 8'b1010_1001; return 1'b1; end
      3'd2: begin s = 8'b1100_0101; return 1'b1; end
      3'd3: begin s = 8'b1110_0011; return 1'b1; end
      3'd4: begin s = 8'b1001_1011; return 1'b1; end
      default: begin s = 8'h00; return 1'b0; end
    endcase
  endfunction

  // expected {dout, busy, done, err, code_ready} for each cycle, scheduled a frame at a time
  localparam logic [4:0] IDLE_E = 5'b00001;
  logic [4:0] exp_q[$];
  logic [4:0] cur = IDLE_E;
  bit         armed = 1'b0;
  bit         chk_en = 1'b0;

  initial begin
    logic [7:0] s;
    forever begin
      @(posedge clk or negedge arst);
      if (!arst) begin
        exp_q.delete();
        cur   = IDLE_E;
        armed = 1'b0;
      end else begin
        if (armed && code_valid && cur[0]) begin
          if (ref_sig(code_in, s)) begin
            exp_q.push_back(5'b00000);
            for (int i = SIG_W - 1; i >= 0; i--)
              exp_q.push_back({s[i], 1'b1, 1'b0, 1'b0, 1'b0});
            for (int g = 1; g <= GAP_CYCLES; g++)
              exp_q.push_back({1'b0, 1'b1, (g == GAP_CYCLES), 1'b0, (g == GAP_CYCLES)});
          end else begin
            exp_q.push_back(5'b00011);
          end
        end
        armed = 1'b1;
        cur = (exp_q.size() > 0) ? exp_q.pop_front() : IDLE_E;
      end
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      if (chk_en) check("cycle {dout,busy,done,err,ready}", {27'd0, dout, busy, done, err, code_ready}, {27'd0, cur});
    end
  end

  task automatic wait_ready();
    int t = 0;
    while (!code_ready && t < 50) begin
      @(negedge clk);
      t++;
    end
    check("ready_timeout", {31'd0, code_ready}, 32'd1);
  endtask

  task automatic send_and_capture(input logic [2:0] code, output logic [11:0] bits,
                                  output int done_idx, output int low_cnt);
    wait_ready();
    code_in    = code;
    code_valid = 1'b1;
    @(negedge clk);
    code_valid = 1'b0;
    low_cnt  = code_ready ? 0 : 1;
    bits     = '0;
    done_idx = -1;
    for (int i = 1; i <= SIG_W + GAP_CYCLES; i++) begin
      @(negedge clk);
      bits = {bits[10:0], dout};
      if (done && done_idx < 0) done_idx = i;
      if (!code_ready) low_cnt++;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    logic [11:0] bits;
    logic [25:0] b2b;
    int          done_idx, low_cnt;

    #1 arst = 1'b0;
    chk_en = 1'b1;
    repeat (2) @(negedge clk);
    check("rst_dout", {31'd0, dout}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_done", {31'd0, done}, 32'd0);
    check("rst_err", {31'd0, err}, 32'd0);
    check("rst_ready", {31'd0, code_ready}, 32'd1);

    // valid already high as reset releases: the release edge must not accept
    code_in    = 3'd1;
    code_valid = 1'b1;
    arst       = 1'b1;
    @(negedge clk);
    check("release_no_accept_ready", {31'd0, code_ready}, 32'd1);
    check("release_no_accept_busy", {31'd0, busy}, 32'd0);

    send_and_capture(3'd1, bits, done_idx, low_cnt);
    check("methane_bits", {20'd0, bits}, {20'd0, 12'b1010_1001_0000});
    check("methane_done_idx", done_idx, 32'd12);
    check("methane_ready_low", low_cnt, 32'd12);

    wait_ready();
    code_in    = 3'd2;
    code_valid = 1'b1;
    b2b        = '0;
    low_cnt    = 0;
    for (int i = 0; i < 26; i++) begin
      @(negedge clk);
      b2b = {b2b[24:0], dout};
      if (i <= 12 && !code_ready) low_cnt++;
      if (i == 0) code_in = 3'd4;
      if (i == 13) code_valid = 1'b0;
    end
    check("b2b_bits", {6'd0, b2b}, {6'd0, 26'b0_11000101_0000_0_10011011_0000});
    check("b2b_ready_low", low_cnt, 32'd12);

    wait_ready();
    code_in    = 3'd6;
    code_valid = 1'b1;
    @(negedge clk);
    code_valid = 1'b0;
    check("bad_err", {31'd0, err}, 32'd1);
    check("bad_ready", {31'd0, code_ready}, 32'd1);
    check("bad_busy", {31'd0, busy}, 32'd0);
    check("bad_dout", {31'd0, dout}, 32'd0);
    @(negedge clk);
    check("bad_err_clear", {31'd0, err}, 32'd0);

    wait_ready();
    code_in    = 3'd3;
    code_valid = 1'b1;
    @(negedge clk);
    code_valid = 1'b0;
    repeat (3) @(negedge clk);
    check("lpg_third_bit", {31'd0, dout}, 32'd1);
    #2 arst = 1'b0;
    #1;
    check("async_rst_dout", {31'd0, dout}, 32'd0);
    check("async_rst_ready", {31'd0, code_ready}, 32'd1);
    check("async_rst_busy", {31'd0, busy}, 32'd0);
    @(negedge clk);
    arst = 1'b1;
    @(negedge clk);
    send_and_capture(3'd1, bits, done_idx, low_cnt);
    check("after_rst_bits", {20'd0, bits}, {20'd0, 12'b1010_1001_0000});

    for (int n = 0; n < 600; n++) begin
      @(negedge clk);
      code_valid = ($urandom_range(0, 3) != 0);
      code_in    = 3'($urandom_range(0, 7));
      if ($urandom_range(0, 99) == 0) begin
        #2 arst = 1'b0;
        #1 arst = 1'b1;
      end
    end
    @(negedge clk);
    code_valid = 1'b0;
    repeat (20) @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
